// File: rtl/tsc_pkg.sv
// tsc_pkg: shared types, default parameters and helper functions for the
// transient-stream capture block.
//   - tsc_state_e : controller states
//   - tsc_phase_e : capture phase (before / after the trigger sample)
//   - clog2()     : pointer / counter width helper
package tsc_pkg;

    localparam int unsigned DefDataW   = 8;
    localparam int unsigned DefDepth   = 32;
    localparam int unsigned DefPreTrig = 8;
    localparam int unsigned DefReqGap  = 4;
    localparam int unsigned DefTimeout = 16;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StGap,
        StRead
    } tsc_state_e;

    typedef enum logic {
        PhPre,
        PhPost
    } tsc_phase_e;

    // Smallest r such that 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tsc_ringbuf.sv
// tsc_ringbuf: DEPTH x DATA_W simple dual-port sample store.
//   clk, rst     : clock, asynchronous active-low reset (read register only)
//   we/waddr/wdat: synchronous write port
//   re/raddr     : read request and address
//   rdat/rvld    : registered read data and its one-cycle qualifier
module tsc_ringbuf
    import tsc_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdat,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdat,
    output logic              rvld
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdat_q;
    logic              rvld_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdat_q <= '0;
            rvld_q <= 1'b0;
        end else begin
            rvld_q <= re;
            if (re) begin
                rdat_q <= mem[raddr];
            end
        end
    end

    assign rdat = rdat_q;
    assign rvld = rvld_q;

endmodule

// File: rtl/tsc_capture.sv
// tsc_capture: paces ADC requests, stores samples in a circular buffer, freezes a
// pre/post-trigger window on a rising threshold crossing and plays it back oldest first.
//   clk, rst         : clock, asynchronous active-low reset
//   start, trig_lvl  : arm pulse and threshold (threshold latched on accepted start)
//   adc_req          : one-cycle request to the ADC
//   adc_rdy, adc_dat : ADC sample strobe and data
//   busy, trd, sbf   : armed / trigger seen / window frozen and readable
//   err              : ADC timeout, sticky until next accepted start
//   rd_en            : read request (READ state only)
//   rd_dat, rd_vld   : read data and its strobe, one cycle after rd_en
module tsc_capture
    import tsc_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned PRE_TRIG = DefPreTrig,
    parameter int unsigned REQ_GAP  = DefReqGap,
    parameter int unsigned TIMEOUT  = DefTimeout
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] trig_lvl,
    output logic              adc_req,
    input  logic              adc_rdy,
    input  logic [DATA_W-1:0] adc_dat,
    output logic              busy,
    output logic              trd,
    output logic              sbf,
    output logic              err,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_dat,
    output logic              rd_vld
);

    localparam int unsigned PtrW   = clog2(DEPTH);
    localparam int unsigned CntMax = (TIMEOUT > REQ_GAP) ? TIMEOUT : REQ_GAP;
    localparam int unsigned CntW   = clog2(CntMax + 1);

    tsc_state_e        state_q, state_d;
    tsc_phase_e        phase_q, phase_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [PtrW-1:0]   trig_addr_q, trig_addr_d;
    logic [PtrW-1:0]   post_q, post_d;
    logic [PtrW-1:0]   samp_cnt_q, samp_cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] lvl_q, lvl_d;
    logic [CntW-1:0]   tmr_q, tmr_d;
    logic              err_q, err_d;
    logic              we, re, hit;

    // samp_cnt saturates at PRE_TRIG, so it also guarantees prev_q holds a real sample.
    assign hit = (phase_q == PhPre) && (adc_dat >= lvl_q) && (prev_q < lvl_q) &&
                 (samp_cnt_q == PtrW'(PRE_TRIG));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_cnt_d    = rd_cnt_q;
        trig_addr_d = trig_addr_q;
        post_d      = post_q;
        samp_cnt_d  = samp_cnt_q;
        prev_d      = prev_q;
        lvl_d       = lvl_q;
        tmr_d       = tmr_q;
        err_d       = err_q;
        we          = 1'b0;
        re          = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    wr_ptr_d   = '0;
                    samp_cnt_d = '0;
                    phase_d    = PhPre;
                    err_d      = 1'b0;
                    lvl_d      = trig_lvl;
                    state_d    = StReq;
                end
            end
            StReq: begin
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (adc_rdy) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PtrW'(1);
                    prev_d   = adc_dat;
                    tmr_d    = '0;
                    state_d  = StGap;
                    if (samp_cnt_q != PtrW'(PRE_TRIG)) begin
                        samp_cnt_d = samp_cnt_q + PtrW'(1);
                    end
                    if (phase_q == PhPost) begin
                        if (post_q == PtrW'(1)) begin
                            // Window complete: oldest retained sample is PRE_TRIG before trigger.
                            rd_ptr_d = trig_addr_q - PtrW'(PRE_TRIG);
                            rd_cnt_d = '0;
                            state_d  = StRead;
                        end else begin
                            post_d = post_q - PtrW'(1);
                        end
                    end else if (hit) begin
                        phase_d     = PhPost;
                        trig_addr_d = wr_ptr_q;
                        post_d      = PtrW'(DEPTH - PRE_TRIG - 1);
                    end
                end else if (tmr_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    phase_d = PhPre;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + CntW'(1);
                end
            end
            StGap: begin
                if (tmr_q == CntW'(REQ_GAP - 1)) begin
                    state_d = StReq;
                end else begin
                    tmr_d = tmr_q + CntW'(1);
                end
            end
            StRead: begin
                if (rd_en) begin
                    re       = 1'b1;
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                    rd_cnt_d = rd_cnt_q + PtrW'(1);
                    if (rd_cnt_q == PtrW'(DEPTH - 1)) begin
                        phase_d = PhPre;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            phase_q     <= PhPre;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_cnt_q    <= '0;
            trig_addr_q <= '0;
            post_q      <= '0;
            samp_cnt_q  <= '0;
            prev_q      <= '0;
            lvl_q       <= '0;
            tmr_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            trig_addr_q <= trig_addr_d;
            post_q      <= post_d;
            samp_cnt_q  <= samp_cnt_d;
            prev_q      <= prev_d;
            lvl_q       <= lvl_d;
            tmr_q       <= tmr_d;
            err_q       <= err_d;
        end
    end

    tsc_ringbuf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PtrW)
    ) u_ringbuf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdat  (adc_dat),
        .re    (re),
        .raddr (rd_ptr_q),
        .rdat  (rd_dat),
        .rvld  (rd_vld)
    );

    assign adc_req = (state_q == StReq);
    assign busy    = (state_q != StIdle);
    assign sbf     = (state_q == StRead);
    assign trd     = (phase_q == PhPost);
    assign err     = err_q;

endmodule
